// File: rtl/cpu_types_pkg.sv
// Shared pipeline types: register index, hazard controller state, latch control vector.
package cpu_types_pkg;

  typedef logic [4:0] regbits_t;

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    DWAIT  = 2'd1,
    DRAIN  = 2'd2,
    HALTED = 2'd3
  } pipe_state_t;

  typedef struct packed {
    logic ifid;
    logic idex;
    logic exmem;
    logic memwb;
  } latch_ctl_t;

  // A load into r0 never creates a dependency, so it is excluded from the compare.
  function automatic logic load_use_hazard(input logic     ld,
                                           input regbits_t wsel,
                                           input regbits_t rs,
                                           input regbits_t rt);
    return ld && (wsel != '0) && ((wsel == rs) || (wsel == rt));
  endfunction

endpackage

// File: rtl/pipe_perf_cnt.sv
// Saturating up-counter with synchronous clear; clear has priority over increment.
module pipe_perf_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             clr,
  input  logic             inc,
  output logic [CNT_W-1:0] cnt
);

  always_ff @(posedge CLK) begin
    if (clr)
      cnt <= '0;
    else if (inc && (cnt != {CNT_W{1'b1}}))
      cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline latch sequencing: load-use stalls, redirect flushes, data-memory waits
// and halt drain, with fetch/data arbitration of the single-port memory.
//
// state  | meaning
// RUN    | normal flow; fetch may be requested
// DWAIT  | data access in MEM pending; no fetch, latches hold until dhit
// DRAIN  | halt committing into MEM/WB; one cycle
// HALTED | pipeline drained; only reset exits
module pipe_hazard_ctrl
  import cpu_types_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             ihit,
  input  logic             dhit,
  input  logic             idex_dREN,
  input  regbits_t         idex_wsel,
  input  regbits_t         ifid_rs,
  input  regbits_t         ifid_rt,
  input  logic             mem_dREN,
  input  logic             mem_dWEN,
  input  logic             mem_redirect,
  input  logic             mem_halt,
  output logic             pc_en,
  output logic             iREN,
  output logic             ifid_en,
  output logic             idex_en,
  output logic             exmem_en,
  output logic             memwb_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             memwb_flush,
  output logic             halt,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  pipe_state_t state, state_nxt;
  latch_ctl_t  en, flush;
  logic        mem_op, adv, lu_hazard, active;
  logic        stall_inc, flush_inc;

  assign mem_op    = mem_dREN | mem_dWEN;
  assign adv       = (~mem_op & ihit) | (mem_op & dhit);
  assign lu_hazard = load_use_hazard(idex_dREN, idex_wsel, ifid_rs, ifid_rt);
  assign active    = (state == RUN) || (state == DWAIT);

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= RUN;
      halt  <= 1'b0;
    end else begin
      state <= state_nxt;
      halt  <= (state_nxt == HALTED);
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      RUN, DWAIT: begin
        if (adv)
          state_nxt = mem_halt ? DRAIN : RUN;
        else
          state_nxt = mem_op ? DWAIT : RUN;
      end
      DRAIN:   state_nxt = HALTED;
      HALTED:  state_nxt = HALTED;
      default: state_nxt = RUN;
    endcase
  end

  always_comb begin
    en        = '0;
    flush     = '0;
    pc_en     = 1'b0;
    iREN      = 1'b0;
    flush_inc = 1'b0;
    if (RST) begin
      flush = '1;
    end else if (active) begin
      iREN = (state == RUN) & ~mem_op;
      if (adv) begin
        if (mem_halt) begin
          flush    = '{ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b0};
          en.memwb = 1'b1;
        end else if (mem_redirect) begin
          en        = '1;
          pc_en     = 1'b1;
          flush     = '{ifid: 1'b1, idex: 1'b1, exmem: 1'b1, memwb: 1'b0};
          flush_inc = 1'b1;
        end else if (lu_hazard) begin
          // Decode instruction holds in IF/ID; a bubble enters ID/EX.
          flush.idex = 1'b1;
          en.exmem   = 1'b1;
          en.memwb   = 1'b1;
        end else begin
          en    = '1;
          pc_en = 1'b1;
        end
      end
    end else if (state == DRAIN) begin
      en.memwb = 1'b1;
    end
  end

  assign ifid_en     = en.ifid;
  assign idex_en     = en.idex;
  assign exmem_en    = en.exmem;
  assign memwb_en    = en.memwb;
  assign ifid_flush  = flush.ifid;
  assign idex_flush  = flush.idex;
  assign exmem_flush = flush.exmem;
  assign memwb_flush = flush.memwb;

  assign stall_inc = ~RST & ~pc_en & (state != HALTED);

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (stall_inc),
    .cnt (stall_cnt)
  );

  pipe_perf_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .CLK (CLK),
    .clr (RST),
    .inc (flush_inc),
    .cnt (flush_cnt)
  );

endmodule
